analog_intl_scan_ctrl: RTL and testbench
========================================

# analog_intl_scan_ctrl

Time-multiplexed scan controller for the BR MPS analog interlock. On each ADC sample strobe it snapshots the eight analog readbacks and steps them one per cycle through a single shared IEEE-754 single-precision comparator against the AXI-programmed set-points. It debounces violations per channel, latches faults, and records the first-out channel. It sits between the AXI set-point register block and the interlock aggregation / gate-kill logic.

## Interface
- C_DBNC_WIDTH, 16, width of per-channel debounce counters and threshold.
- i_clk  in  1  system clock (the AXI clock domain).
- i_rst  in  1  reset, synchronous, active-high.
- i_scan_tick  in  1  one-cycle strobe: new ADC data valid.
- i_ch_data  in  8x32  fp32 readbacks. Channel order:
  - 0 output current
  - 1 output voltage
  - 2 DC current
  - 3 DC voltage (over)
  - 4 DC voltage (under)
  - 5 IGBT temperature
  - 6 inlet temperature
  - 7 outlet temperature
- i_ch_sp  in  8x32  fp32 set-points, same order.
- i_intl_en  in  8  per-channel enable; 0 = channel ignored.
- i_dbnc_cnt  in  C_DBNC_WIDTH  consecutive violating scans required to latch a fault. 0 and 1 are equivalent.
- i_intl_clr  in  1  one-cycle clear of latches, counters, first-out, overrun.
- o_intl_state  out  8  latched fault per channel.
- o_intl_any  out  1  OR of o_intl_state.
- o_first_ch  out  3  channel index of the first latched fault.
- o_first_valid  out  1  o_first_ch valid.
- o_scan_busy  out  1  scan in progress.
- o_scan_done  out  1  one-cycle pulse at end of scan.
- o_scan_ovr  out  1  sticky; a tick arrived while busy.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE/DONE + i_scan_tick → SCAN. Snapshot i_ch_data and i_ch_sp, idx←0.
  - SCAN: idx increments each cycle 0..7. After idx 7 the pipeline drains one cycle, then → DONE.
  - DONE → IDLE unless a tick is accepted.
- Compare modes:
  - ch 0,1 ABS_OVER: violation if |x| > sp (sign bit of x cleared).
  - ch 2,3,5,6,7 OVER: violation if x > sp.
  - ch 4 UNDER: violation if x < sp.
  - Ordering is full signed fp32 compare; +0 == −0.
  - A NaN sample (exp=0xFF, mantissa≠0) is always a violation. A NaN set-point is never a violation.
- Evaluation per channel:
  - Violation & enabled: counter += 1, saturating at all-ones. If new counter ≥ max(i_dbnc_cnt,1), set the latch.
  - No violation or disabled: counter ← 0. Latch holds.
  - Latches clear only on i_intl_clr or i_rst.
- First-out: the first latch set while o_first_valid=0 loads o_first_ch and sets o_first_valid. Within a scan, the lowest channel wins.
- i_intl_clr:
  - Clears latches, counters, first-out and o_scan_ovr at that edge. An in-flight scan continues.
  - If the same edge evaluates a violating channel, the evaluation uses counter=0 and the set wins.
- i_scan_tick while in SCAN: the tick is dropped and o_scan_ovr is set.
- Reset mid-scan: abandon the scan, no o_scan_done.
- Reset values of all outputs and counters: 0.

## Timing
- Tick sampled at edge 0.
  - Cycles 1–8: comparator input = ch 0–7.
  - Comparator result is registered one cycle later.
  - Latch for ch k is visible from cycle k+3.
- o_scan_busy is high in cycles 1–9. o_scan_done is high in cycle 10; ch 7 is visible in cycle 10.
- A tick at edge 10 (DONE) is accepted with no bubble. The minimum tick period is 10 cycles.
- Total tick-to-done latency: 10 cycles.

## Structure
- Package analog_intl_pkg holds:
  - NUM_CH=8
  - channel index constants
  - cmp_mode_t {ABS_OVER, OVER, UNDER}
  - FSM state type
  - the per-channel mode constant array
- Sub-module fp32_cmp: registered single-cycle fp32 comparator.
  - Inputs: a, b, mode.
  - Output: violation (includes NaN rule).
  - This is the shared resource being scheduled.
- The top level contains the FSM, snapshot registers, index/valid pipeline, counters, latches and first-out.

## Test plan
- Debounce threshold:
  - Stimulus: ch0 x=0x437A0000 (250.0), sp=0x43460000 (198.0), en=0x01, dbnc=3, three ticks.
  - Required: latch is 0 after scans 1–2 and 1 from cycle 3 of scan 3; o_first_ch=0.
- ABS_OVER negative input:
  - Stimulus: ch1 x=0xC37A0000 (−250.0), sp=0x43460000 (198.0), dbnc=1.
  - Required: o_intl_state[1]=1 at cycle 4 after the tick.
- Under-voltage and first-out:
  - Stimulus: ch4 x=0x42C80000 (100.0), sp=0x43460000 (198.0), together with ch6 over.
  - Required: bits 4 and 6 set; o_first_ch=4.
- Disabled channel and counter reset:
  - Stimulus: a disabled violating channel.
  - Required: it never latches.
  - Stimulus: an enabled channel alternating violation/no-violation with dbnc=2.
  - Required: it never latches.
- Overrun and clear:
  - Stimulus: tick at cycle 5 of a scan.
  - Required: o_scan_ovr=1, only one o_scan_done.
  - Stimulus: i_intl_clr.
  - Required: o_scan_ovr, latches and o_first_valid all 0.
- Reset and NaN:
  - Stimulus: i_rst at cycle 4 of a scan.
  - Required: no o_scan_done; all outputs 0.
  - Stimulus: sample 0x7FC00000 (NaN) on ch5, dbnc=1.
  - Required: ch5 latches.

Source files
------------

// File: rtl/analog_intl_pkg.sv
// Shared types and constants for the BR MPS analog interlock scan controller.
package analog_intl_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned CH_W   = 3;

  localparam int unsigned CH_OUT_CURR  = 0;
  localparam int unsigned CH_OUT_VOLT  = 1;
  localparam int unsigned CH_DC_CURR   = 2;
  localparam int unsigned CH_DC_OVOLT  = 3;
  localparam int unsigned CH_DC_UVOLT  = 4;
  localparam int unsigned CH_IGBT_TEMP = 5;
  localparam int unsigned CH_IN_TEMP   = 6;
  localparam int unsigned CH_OUT_TEMP  = 7;

  typedef enum logic [1:0] {ABS_OVER, OVER, UNDER} cmp_mode_t;

  typedef enum logic [1:0] {StIdle, StScan, StDone} scan_state_t;

  localparam cmp_mode_t CH_MODE [NUM_CH] = '{
    ABS_OVER, ABS_OVER, OVER, OVER, UNDER, OVER, OVER, OVER
  };

  function automatic logic fp32_is_nan(logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  // Maps fp32 onto an unsigned key whose ordering matches numeric ordering (NaN excluded).
  function automatic logic [31:0] fp32_key(logic [31:0] x);
    return x[31] ? ~x : {1'b1, x[30:0]};
  endfunction

endpackage

// File: rtl/fp32_cmp.sv
// Registered single-cycle fp32 threshold comparator shared by all interlock channels.
module fp32_cmp
  import analog_intl_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  cmp_mode_t   i_mode,
  output logic        o_violation
);

  logic [31:0] a_eff;
  logic [31:0] key_a;
  logic [31:0] key_b;
  logic        both_zero;
  logic        viol_d;

  always_comb begin
    a_eff = i_a;
    if (i_mode == ABS_OVER) begin
      a_eff[31] = 1'b0;
    end
    key_a     = fp32_key(a_eff);
    key_b     = fp32_key(i_b);
    // +0 and -0 map to adjacent keys, so equal zeros are caught explicitly.
    both_zero = (a_eff[30:0] == '0) && (i_b[30:0] == '0);
    viol_d    = 1'b0;
    if (fp32_is_nan(a_eff)) begin
      viol_d = 1'b1;
    end else if (fp32_is_nan(i_b) || both_zero) begin
      viol_d = 1'b0;
    end else if (i_mode == UNDER) begin
      viol_d = key_a < key_b;
    end else begin
      viol_d = key_a > key_b;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_violation <= 1'b0;
    end else begin
      o_violation <= viol_d;
    end
  end

endmodule

// File: rtl/analog_intl_scan_ctrl.sv
// Time-multiplexed analog interlock scanner: snapshots eight fp32 readbacks per tick and
// checks them one per cycle through a shared comparator, with debounce, latch and first-out.
module analog_intl_scan_ctrl
  import analog_intl_pkg::*;
#(
  parameter int unsigned C_DBNC_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_scan_tick,
  input  logic [NUM_CH-1:0][31:0] i_ch_data,
  input  logic [NUM_CH-1:0][31:0] i_ch_sp,
  input  logic [NUM_CH-1:0]       i_intl_en,
  input  logic [C_DBNC_WIDTH-1:0] i_dbnc_cnt,
  input  logic                    i_intl_clr,
  output logic [NUM_CH-1:0]       o_intl_state,
  output logic                    o_intl_any,
  output logic [CH_W-1:0]         o_first_ch,
  output logic                    o_first_valid,
  output logic                    o_scan_busy,
  output logic                    o_scan_done,
  output logic                    o_scan_ovr
);

  scan_state_t             state_q, state_d;
  logic [3:0]              idx_q, idx_d;
  logic                    snap;
  logic [NUM_CH-1:0][31:0] data_q, sp_q;
  logic                    cmp_valid;
  logic [CH_W-1:0]         cmp_ch;
  logic                    cmp_viol;
  logic                    res_valid_q;
  logic [CH_W-1:0]         res_ch_q;

  logic [C_DBNC_WIDTH-1:0] cnt_q [NUM_CH];
  logic [C_DBNC_WIDTH-1:0] cnt_d [NUM_CH];
  logic [C_DBNC_WIDTH-1:0] thr;
  logic [C_DBNC_WIDTH-1:0] cnt_inc;
  logic [NUM_CH-1:0]       latch_q, latch_d;
  logic [CH_W-1:0]         first_ch_q, first_ch_d;
  logic                    first_valid_q, first_valid_d;
  logic                    ovr_q, ovr_d;

  // Scan sequencing: idx 0..7 feeds the comparator, idx 8 is the pipeline drain cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_scan_tick) begin
          state_d = StScan;
          idx_d   = '0;
          snap    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StScan: begin
        if (idx_q == 4'd8) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmp_valid = (state_q == StScan) && !idx_q[3];
  assign cmp_ch    = idx_q[CH_W-1:0];

  fp32_cmp u_cmp (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_a         (data_q[cmp_ch]),
    .i_b         (sp_q[cmp_ch]),
    .i_mode      (CH_MODE[cmp_ch]),
    .o_violation (cmp_viol)
  );

  // Clear is applied first so a same-edge evaluation starts from zero and its set wins.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = i_intl_clr ? '0 : cnt_q[i];
    end
    latch_d       = i_intl_clr ? '0 : latch_q;
    first_ch_d    = i_intl_clr ? '0 : first_ch_q;
    first_valid_d = i_intl_clr ? 1'b0 : first_valid_q;
    ovr_d         = i_intl_clr ? 1'b0 : ovr_q;
    thr           = (i_dbnc_cnt == '0) ? C_DBNC_WIDTH'(1) : i_dbnc_cnt;
    cnt_inc       = '0;

    if (i_scan_tick && (state_q == StScan)) begin
      ovr_d = 1'b1;
    end

    if (res_valid_q) begin
      if (cmp_viol && i_intl_en[res_ch_q]) begin
        cnt_inc = (&cnt_d[res_ch_q]) ? cnt_d[res_ch_q] : cnt_d[res_ch_q] + C_DBNC_WIDTH'(1);
        cnt_d[res_ch_q] = cnt_inc;
        if (cnt_inc >= thr) begin
          latch_d[res_ch_q] = 1'b1;
          if (!first_valid_d) begin
            first_ch_d    = res_ch_q;
            first_valid_d = 1'b1;
          end
        end
      end else begin
        cnt_d[res_ch_q] = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      data_q        <= '0;
      sp_q          <= '0;
      res_valid_q   <= 1'b0;
      res_ch_q      <= '0;
      latch_q       <= '0;
      first_ch_q    <= '0;
      first_valid_q <= 1'b0;
      ovr_q         <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      if (snap) begin
        data_q <= i_ch_data;
        sp_q   <= i_ch_sp;
      end
      res_valid_q   <= cmp_valid;
      res_ch_q      <= cmp_ch;
      latch_q       <= latch_d;
      first_ch_q    <= first_ch_d;
      first_valid_q <= first_valid_d;
      ovr_q         <= ovr_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign o_intl_state  = latch_q;
  assign o_intl_any    = |latch_q;
  assign o_first_ch    = first_ch_q;
  assign o_first_valid = first_valid_q;
  assign o_scan_busy   = (state_q == StScan);
  assign o_scan_done   = (state_q == StDone);
  assign o_scan_ovr    = ovr_q;

endmodule

// File: tb/tb_analog_intl_scan_ctrl.sv
// Directed bench for analog_intl_scan_ctrl: debounce, compare modes, first-out, overrun, reset.
module tb_analog_intl_scan_ctrl;

  localparam logic [31:0] F250  = 32'h437A0000;
  localparam logic [31:0] FM250 = 32'hC37A0000;
  localparam logic [31:0] F198  = 32'h43460000;
  localparam logic [31:0] F100  = 32'h42C80000;
  localparam logic [31:0] F50   = 32'h42480000;
  localparam logic [31:0] FNAN  = 32'h7FC00000;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick;
  logic [7:0][31:0] ch_data;
  logic [7:0][31:0] ch_sp;
  logic [7:0]       intl_en;
  logic [15:0]      dbnc;
  logic             clr;
  logic [7:0]       intl_state;
  logic             intl_any;
  logic [2:0]       first_ch;
  logic             first_valid;
  logic             scan_busy;
  logic             scan_done;
  logic             scan_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  analog_intl_scan_ctrl #(.C_DBNC_WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_scan_tick   (tick),
    .i_ch_data     (ch_data),
    .i_ch_sp       (ch_sp),
    .i_intl_en     (intl_en),
    .i_dbnc_cnt    (dbnc),
    .i_intl_clr    (clr),
    .o_intl_state  (intl_state),
    .o_intl_any    (intl_any),
    .o_first_ch    (first_ch),
    .o_first_valid (first_valid),
    .o_scan_busy   (scan_busy),
    .o_scan_done   (scan_done),
    .o_scan_ovr    (scan_ovr)
  );

  task automatic set_defaults();
    for (int i = 0; i < 8; i++) begin
      ch_data[i] = F100;
      ch_sp[i]   = F198;
    end
    ch_sp[4] = F50;
    intl_en  = 8'h00;
    dbnc     = 16'd1;
  endtask

  // Returns at the falling edge of cycle 1 (tick sampled at edge 0).
  task automatic start_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!scan_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!scan_done) begin
      n_fail++;
      $display("FAIL %s_done_timeout got=%b exp=1", tag, scan_done);
    end
  endtask

  task automatic run_scan(input string tag);
    start_tick();
    wait_done(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({intl_state, intl_any, first_ch, first_valid, scan_busy, scan_done, scan_ovr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0",
               {intl_state, intl_any, first_ch, first_valid, scan_busy, scan_done, scan_ovr});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_debounce();
    set_defaults();
    ch_data[0] = F250;
    intl_en    = 8'h01;
    dbnc       = 16'd3;
    run_scan("dbnc1");
    n_checks++;
    if (intl_state !== 8'h00) begin
      n_fail++; $display("FAIL dbnc_scan1 got=%h exp=00", intl_state);
    end
    run_scan("dbnc2");
    n_checks++;
    if (intl_state !== 8'h00) begin
      n_fail++; $display("FAIL dbnc_scan2 got=%h exp=00", intl_state);
    end
    start_tick();
    n_checks++;
    if (scan_busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_cycle1 got=%b exp=1", scan_busy);
    end
    @(negedge clk);
    n_checks++;
    if (intl_state[0] !== 1'b0) begin
      n_fail++; $display("FAIL dbnc_cycle2 got=%b exp=0", intl_state[0]);
    end
    @(negedge clk);
    n_checks++;
    if (intl_state[0] !== 1'b1) begin
      n_fail++; $display("FAIL dbnc_cycle3 got=%b exp=1", intl_state[0]);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if ({scan_busy, scan_done} !== 2'b10) begin
      n_fail++; $display("FAIL cycle9_busy_done got=%b exp=10", {scan_busy, scan_done});
    end
    @(negedge clk);
    n_checks++;
    if ({scan_busy, scan_done} !== 2'b01) begin
      n_fail++; $display("FAIL cycle10_busy_done got=%b exp=01", {scan_busy, scan_done});
    end
    n_checks++;
    if ({first_valid, first_ch, intl_any} !== 5'b1_000_1) begin
      n_fail++; $display("FAIL dbnc_first got=%b exp=10001", {first_valid, first_ch, intl_any});
    end
  endtask

  task automatic test_back_to_back();
    set_defaults();
    start_tick();
    repeat (9) @(negedge clk);
    tick = 1'b1;  // sampled at edge 10 while in DONE
    @(negedge clk);
    tick = 1'b0;
    n_checks++;
    if ({scan_busy, scan_ovr} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_accept got=%b exp=10", {scan_busy, scan_ovr});
    end
    repeat (9) @(negedge clk);
    n_checks++;
    if (scan_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done got=%b exp=1", scan_done);
    end
  endtask

  task automatic test_abs_over();
    pulse_clr();
    set_defaults();
    ch_data[1] = FM250;
    intl_en    = 8'h02;
    start_tick();
    repeat (2) @(negedge clk);
    n_checks++;
    if (intl_state[1] !== 1'b0) begin
      n_fail++; $display("FAIL abs_cycle3 got=%b exp=0", intl_state[1]);
    end
    @(negedge clk);
    n_checks++;
    if (intl_state[1] !== 1'b1) begin
      n_fail++; $display("FAIL abs_cycle4 got=%b exp=1", intl_state[1]);
    end
    wait_done("abs");
    n_checks++;
    if (first_ch !== 3'd1) begin
      n_fail++; $display("FAIL abs_first got=%0d exp=1", first_ch);
    end
  endtask

  task automatic test_under_first_out();
    pulse_clr();
    set_defaults();
    ch_data[4] = F100;
    ch_sp[4]   = F198;
    ch_data[6] = F250;
    intl_en    = 8'h50;
    run_scan("under");
    n_checks++;
    if (intl_state !== 8'h50) begin
      n_fail++; $display("FAIL under_state got=%h exp=50", intl_state);
    end
    n_checks++;
    if ({first_valid, first_ch} !== 4'b1_100) begin
      n_fail++; $display("FAIL under_first got=%b exp=1100", {first_valid, first_ch});
    end
  endtask

  task automatic test_disabled_and_reset_counter();
    pulse_clr();
    set_defaults();
    ch_data[2] = F250;
    run_scan("dis1");
    run_scan("dis2");
    n_checks++;
    if (intl_state !== 8'h00) begin
      n_fail++; $display("FAIL disabled_state got=%h exp=00", intl_state);
    end
    ch_data[2] = F100;
    intl_en    = 8'h08;
    dbnc       = 16'd2;
    for (int s = 0; s < 5; s++) begin
      ch_data[3] = (s % 2 == 0) ? F250 : F100;
      run_scan("alt");
    end
    n_checks++;
    if (intl_state !== 8'h00) begin
      n_fail++; $display("FAIL alternating_state got=%h exp=00", intl_state);
    end
    ch_data[3] = F250;
    run_scan("alt_final");
    n_checks++;
    if (intl_state !== 8'h08) begin
      n_fail++; $display("FAIL consecutive_state got=%h exp=08", intl_state);
    end
  endtask

  task automatic test_overrun_clear();
    int dones = 0;
    start_tick();
    repeat (4) @(negedge clk);
    tick = 1'b1;  // sampled at edge 5, mid-scan
    @(negedge clk);
    tick = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (scan_done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL ovr_done_count got=%0d exp=1", dones);
    end
    n_checks++;
    if ({scan_ovr, intl_state[3]} !== 2'b11) begin
      n_fail++; $display("FAIL ovr_set got=%b exp=11", {scan_ovr, intl_state[3]});
    end
    pulse_clr();
    n_checks++;
    if ({scan_ovr, intl_state, first_valid} !== 10'b0) begin
      n_fail++; $display("FAIL clr_state got=%b exp=0", {scan_ovr, intl_state, first_valid});
    end
  endtask

  task automatic test_reset_mid_scan_and_nan();
    int dones = 0;
    set_defaults();
    ch_data[0] = F250;
    intl_en    = 8'h01;
    start_tick();
    repeat (2) @(negedge clk);
    n_checks++;
    if (intl_state[0] !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_latch got=%b exp=1", intl_state[0]);
    end
    @(negedge clk);
    rst = 1'b1;  // sampled at edge 4
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (scan_done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++; $display("FAIL rst_done_count got=%0d exp=0", dones);
    end
    n_checks++;
    if ({intl_state, intl_any, first_ch, first_valid, scan_busy, scan_done, scan_ovr} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got=%h exp=0",
               {intl_state, intl_any, first_ch, first_valid, scan_busy, scan_done, scan_ovr});
    end
    set_defaults();
    ch_data[5] = FNAN;
    ch_data[2] = F250;
    ch_sp[2]   = FNAN;
    intl_en    = 8'h24;
    run_scan("nan");
    n_checks++;
    if (intl_state !== 8'h20) begin
      n_fail++; $display("FAIL nan_state got=%h exp=20", intl_state);
    end
    n_checks++;
    if ({first_valid, first_ch} !== 4'b1_101) begin
      n_fail++; $display("FAIL nan_first got=%b exp=1101", {first_valid, first_ch});
    end
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    clr  = 1'b0;
    set_defaults();
    test_reset();
    test_debounce();
    test_back_to_back();
    test_abs_over();
    test_under_first_out();
    test_disabled_and_reset_counter();
    test_overrun_clear();
    test_reset_mid_scan_and_nan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
